// File: rtl/rv_exec_issue_ctrl.sv
// Issue controller in front of the RV64 execute stage: routes ALU/MDU ops, tracks the
// single outstanding MDU destination for hazards and arbitrates the shared GPR write-back.
module rv_exec_issue_ctrl #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned MD_TIMEOUT = 255,
  parameter int unsigned STALL_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_is_md_i,
  input  logic [REG_AW-1:0] in_rd_i,
  input  logic [REG_AW-1:0] in_rs1_i,
  input  logic [REG_AW-1:0] in_rs2_i,
  input  logic              in_uses_rs2_i,
  output logic              alu_issue_o,
  output logic              md_start_o,
  output logic [REG_AW-1:0] iss_rd_o,
  input  logic              md_done_i,
  output logic              wb_valid_o,
  output logic              wb_src_o,
  output logic [REG_AW-1:0] wb_rd_o,
  output logic              md_timeout_o,
  output logic [STALL_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  localparam logic [7:0]         TMO_LAST  = 8'(MD_TIMEOUT - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = {STALL_W{1'b1}};
  localparam logic [REG_AW-1:0]  RD_ZERO   = {REG_AW{1'b0}};

  state_e              state_q, state_d;
  logic [7:0]          timer_q, timer_d;
  logic                pend_v_q, pend_v_d;
  logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
  logic                alu_issue_q, alu_issue_d;
  logic                md_start_q, md_start_d;
  logic [REG_AW-1:0]   iss_rd_q, iss_rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic                wb_src_q, wb_src_d;
  logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
  logic                md_timeout_q, md_timeout_d;
  logic [STALL_W-1:0]  stall_q, stall_d;

  logic md_done_eff;
  logic hazard;
  logic in_ready;
  logic accept;

  // Hazard detection and the input handshake; md_done is not honoured in the md_start cycle.
  always_comb begin
    md_done_eff = (state_q == ST_MD_BUSY) && md_done_i && !md_start_q;
    hazard      = pend_v_q && ((in_rs1_i == pend_rd_q) ||
                               (in_uses_rs2_i && (in_rs2_i == pend_rd_q)) ||
                               (in_rd_i == pend_rd_q));
    if (!rst_ni) begin
      in_ready = 1'b0;
    end else if (state_q == ST_ERR) begin
      in_ready = 1'b0;
    end else if (hazard) begin
      in_ready = 1'b0;
    end else if (in_is_md_i) begin
      in_ready = (state_q == ST_IDLE);
    end else begin
      // an ALU write-back would collide with the MDU write-back on the same edge
      in_ready = !md_done_eff;
    end
    accept = in_valid_i && in_ready;
  end

  // Next-state: FSM, timeout timer, scoreboard, issue pulses, write-back arbitration, stall counter.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pend_v_d     = pend_v_q;
    pend_rd_d    = pend_rd_q;
    md_timeout_d = md_timeout_q;
    alu_issue_d  = 1'b0;
    md_start_d   = 1'b0;
    iss_rd_d     = RD_ZERO;
    wb_valid_d   = 1'b0;
    wb_src_d     = 1'b0;
    wb_rd_d      = RD_ZERO;
    stall_d      = stall_q;

    case (state_q)
      ST_IDLE: begin
        if (accept && in_is_md_i) begin
          state_d = ST_MD_BUSY;
          timer_d = 8'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MD_BUSY: begin
        if (md_done_eff) begin
          state_d = ST_IDLE;
        end else if (timer_q == TMO_LAST) begin
          state_d      = ST_ERR;
          md_timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (md_done_eff) begin
      pend_v_d = 1'b0;
    end else if (accept && in_is_md_i && (in_rd_i != RD_ZERO)) begin
      pend_v_d  = 1'b1;
      pend_rd_d = in_rd_i;
    end else begin
      pend_v_d = pend_v_q;
    end

    if (accept) begin
      alu_issue_d = !in_is_md_i;
      md_start_d  = in_is_md_i;
      iss_rd_d    = in_rd_i;
    end else begin
      alu_issue_d = 1'b0;
    end

    if (md_done_eff) begin
      wb_valid_d = pend_v_q;
      wb_src_d   = pend_v_q;
      wb_rd_d    = pend_v_q ? pend_rd_q : RD_ZERO;
    end else if (accept && !in_is_md_i && (in_rd_i != RD_ZERO)) begin
      wb_valid_d = 1'b1;
      wb_src_d   = 1'b0;
      wb_rd_d    = in_rd_i;
    end else begin
      wb_valid_d = 1'b0;
    end

    if (in_valid_i && !in_ready && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_W'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      timer_q      <= 8'd0;
      pend_v_q     <= 1'b0;
      pend_rd_q    <= RD_ZERO;
      alu_issue_q  <= 1'b0;
      md_start_q   <= 1'b0;
      iss_rd_q     <= RD_ZERO;
      wb_valid_q   <= 1'b0;
      wb_src_q     <= 1'b0;
      wb_rd_q      <= RD_ZERO;
      md_timeout_q <= 1'b0;
      stall_q      <= {STALL_W{1'b0}};
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pend_v_q     <= pend_v_d;
      pend_rd_q    <= pend_rd_d;
      alu_issue_q  <= alu_issue_d;
      md_start_q   <= md_start_d;
      iss_rd_q     <= iss_rd_d;
      wb_valid_q   <= wb_valid_d;
      wb_src_q     <= wb_src_d;
      wb_rd_q      <= wb_rd_d;
      md_timeout_q <= md_timeout_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready_o   = in_ready;
  assign alu_issue_o  = alu_issue_q;
  assign md_start_o   = md_start_q;
  assign iss_rd_o     = iss_rd_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_src_o     = wb_src_q;
  assign wb_rd_o      = wb_rd_q;
  assign md_timeout_o = md_timeout_q;
  assign stall_cnt_o  = stall_q;

endmodule
